// File: rtl/adder_result_accumulator_if.sv
// Handshake and data bundle between an upstream adder, the result
// accumulator and the downstream consumer of the accumulated total.
interface adder_result_accumulator_if #(
    parameter int ACC_W = 12
);
    logic             start;
    logic [3:0]       num_terms;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       sum;
    logic             cy_out;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;

    // Driver side: issues commands, supplies adder results, consumes totals.
    modport master (
        output start, num_terms, in_valid, sum, cy_out, out_ready,
        input  in_ready, out_valid, acc_out, overflow, busy
    );

    // Accumulator side.
    modport slave (
        input  start, num_terms, in_valid, sum, cy_out, out_ready,
        output in_ready, out_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates a programmed number of 9-bit adder results ({cy_out,sum})
// into an ACC_W-bit total, flags any wrap with a sticky overflow bit and
// presents the total with a valid/ready handshake.
module adder_result_accumulator #(
    parameter int ACC_W = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    adder_result_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [ACC_W:0]   add_res;

    // Returns {carry, total} of the accumulator plus a zero-extended term.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [8:0]       term);
        logic [ACC_W:0] ext_acc;
        logic [ACC_W:0] ext_term;
        ext_acc  = {1'b0, acc};
        ext_term = {{(ACC_W-8){1'b0}}, term};
        return ext_acc + ext_term;
    endfunction

    // Next-state, accumulator, overflow and counter updates.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        add_res = acc_add(acc_q, {bus.cy_out, bus.sum});
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.num_terms;
                    state_d = (bus.num_terms == 4'd0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                // in_ready is implied by being in ACCUM
                if (bus.in_valid) begin
                    acc_d = add_res[ACC_W-1:0];
                    ovf_d = ovf_q | add_res[ACC_W];
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode directly from the state register so they
    // drop the instant reset asserts.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator: table of accumulation jobs
// plus hand-written reset-abort sequences.
module tb_adder_result_accumulator;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    adder_result_accumulator_if #(.ACC_W(12)) bus();

    adder_result_accumulator #(.ACC_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   n;
        logic [134:0] terms;   // term i at [i*9 +: 9]
        logic [11:0]  exp_acc;
        logic         exp_ovf;
        int           gap;
        int           hold;
        bit           poke;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [134:0] fill(input logic [8:0] v);
        return {15{v}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'h0);
        check({tag, "_busy"},      32'(bus.busy),      32'h0);
        check({tag, "_acc_out"},   32'(bus.acc_out),   32'h0);
        check({tag, "_overflow"},  32'(bus.overflow),  32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        logic [11:0] snap;
        t = $sformatf("v%0d", idx);
        bus.start     = 1'b1;
        bus.num_terms = v.n;
        step();
        bus.start     = 1'b0;
        bus.num_terms = 4'd0;
        check({t, "_in_ready_after_start"}, 32'(bus.in_ready), 32'(v.n != 4'd0));
        check({t, "_acc_cleared"},          32'(bus.acc_out),  32'h0);
        check({t, "_busy"},                 32'(bus.busy),     32'h1);
        for (int i = 0; i < int'(v.n); i++) begin
            for (int g = 0; g < v.gap; g++) begin
                snap          = bus.acc_out;
                bus.in_valid  = 1'b0;
                bus.start     = v.poke;
                bus.num_terms = v.poke ? 4'hF : 4'd0;
                step();
                check({t, "_gap_in_ready"}, 32'(bus.in_ready), 32'h1);
                check({t, "_gap_acc_held"}, 32'(bus.acc_out),  32'(snap));
            end
            bus.start                = 1'b0;
            bus.num_terms            = 4'd0;
            bus.in_valid             = 1'b1;
            {bus.cy_out, bus.sum}    = v.terms[i*9 +: 9];
            step();
            bus.in_valid             = 1'b0;
        end
        check({t, "_out_valid"}, 32'(bus.out_valid), 32'h1);
        check({t, "_acc_out"},   32'(bus.acc_out),   32'(v.exp_acc));
        check({t, "_overflow"},  32'(bus.overflow),  32'(v.exp_ovf));
        for (int h = 0; h < v.hold; h++) begin
            bus.in_valid          = 1'b1;
            {bus.cy_out, bus.sum} = 9'h1FF;
            bus.out_ready         = 1'b0;
            bus.start             = v.poke;
            bus.num_terms         = 4'd1;
            step();
            check({t, "_hold_out_valid"}, 32'(bus.out_valid), 32'h1);
            check({t, "_hold_in_ready"},  32'(bus.in_ready),  32'h0);
            check({t, "_hold_acc"},       32'(bus.acc_out),   32'(v.exp_acc));
            check({t, "_hold_ovf"},       32'(bus.overflow),  32'(v.exp_ovf));
        end
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.num_terms = 4'd0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({t, "_idle_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({t, "_idle_busy"},      32'(bus.busy),      32'h0);
        check({t, "_idle_acc_kept"},  32'(bus.acc_out),   32'(v.exp_acc));
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        // n, terms, exp_acc, exp_ovf, gap, hold, poke
        vecs[0] = '{4'd3, {108'b0, 9'h080, 9'h115, 9'h00C}, 12'h1A1, 1'b0, 0, 0, 1'b0};
        vecs[1] = '{4'd9, fill(9'h1FF), 12'h1F7, 1'b1, 0, 0, 1'b0};
        vecs[2] = '{4'd0, 135'b0, 12'h000, 1'b0, 0, 2, 1'b0};
        vecs[3] = '{4'd2, {117'b0, 9'h0AA, 9'h155}, 12'h1FF, 1'b0, 3, 4, 1'b0};
        vecs[4] = '{4'd3, {108'b0, 9'h080, 9'h115, 9'h00C}, 12'h1A1, 1'b0, 1, 2, 1'b1};
        vecs[5] = '{4'd15, fill(9'h1FF), 12'hDF1, 1'b1, 0, 0, 1'b0};
        vecs[6] = '{4'd8, fill(9'h1FF), 12'hFF8, 1'b0, 0, 0, 1'b0};
        vecs[7] = '{4'd9, fill(9'h1FF), 12'h000, 1'b1, 0, 0, 1'b0};
        vecs[7].terms[72 +: 9] = 9'h008;
        vecs[8] = '{4'd10, fill(9'h1FF), 12'h1F8, 1'b1, 0, 1, 1'b0};
        vecs[8].terms[81 +: 9] = 9'h001;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.num_terms = 4'd0;
        bus.in_valid  = 1'b0;
        bus.sum       = 8'h00;
        bus.cy_out    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();
        check_zero_outputs("post_reset_idle");

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], k);
        end

        // Reset between clock edges after one of three terms.
        bus.start     = 1'b1;
        bus.num_terms = 4'd3;
        step();
        bus.start     = 1'b0;
        bus.num_terms = 4'd0;
        bus.in_valid  = 1'b1;
        {bus.cy_out, bus.sum} = 9'h1FF;
        step();
        bus.in_valid  = 1'b0;
        check("abort_accum_acc_before", 32'(bus.acc_out), 32'h1FF);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort_accum");
        step();
        rst_n = 1'b1;
        v = '{4'd1, {126'b0, 9'h005}, 12'h005, 1'b0, 0, 0, 1'b0};
        run_vec(v, 10);

        // Reset between clock edges while holding a result.
        bus.start     = 1'b1;
        bus.num_terms = 4'd1;
        step();
        bus.start     = 1'b0;
        bus.in_valid  = 1'b1;
        {bus.cy_out, bus.sum} = 9'h0FF;
        step();
        bus.in_valid  = 1'b0;
        check("abort_hold_valid_before", 32'(bus.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort_hold");
        step();
        rst_n = 1'b1;
        v = '{4'd2, {117'b0, 9'h100, 9'h011}, 12'h111, 1'b0, 0, 0, 1'b0};
        run_vec(v, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_accumulator.md
ADDER_RESULT_ACCUMULATOR -- requirements
Module: adder_result_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 12, meaning the accumulator width in bits; legal range 10..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to begin a new accumulation, sampled only in IDLE.
REQ-005 The block SHALL have port num_terms, input, 4, the number of adder results to accumulate, sampled with start.
REQ-006 The block SHALL have port in_valid, input, 1, meaning the upstream adder result is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts a result this cycle.
REQ-008 The block SHALL have port sum, input, 8, the upstream ripple-carry adder sum.
REQ-009 The block SHALL have port cy_out, input, 1, the upstream adder carry-out.
REQ-010 The block SHALL have port out_valid, output, 1, meaning acc_out and overflow hold a final result.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the downstream stage accepts the result.
REQ-012 The block SHALL have port acc_out, output, ACC_W, the registered accumulated total.
REQ-013 The block SHALL have port overflow, output, 1, a sticky wrap flag for the current accumulation.
REQ-014 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-016 In IDLE with start=1 and num_terms!=0, the block SHALL clear acc_out and overflow, load the remaining-term counter with num_terms, and enter ACCUM.
REQ-017 In IDLE with start=1 and num_terms=0, the block SHALL clear acc_out and overflow and enter HOLD directly, so a zero result is presented.
REQ-018 start SHALL be ignored in ACCUM and HOLD.
REQ-019 in_ready SHALL be 1 only in ACCUM, and SHALL be driven combinationally from the state register.
REQ-020 A term SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; the term value is {cy_out,sum}, 9 bits, zero-extended to ACC_W.
REQ-021 On each accepted term, acc_out SHALL become (acc_out + term) mod 2^ACC_W, and the counter SHALL decrement by one.
REQ-022 A carry out of bit ACC_W-1 on any accepted term SHALL set overflow to 1; overflow SHALL stay set until the next start or reset.
REQ-023 When the last term is accepted (counter=1), the block SHALL enter HOLD, and out_valid SHALL be 1 on the next cycle, giving one cycle of latency.
REQ-024 In ACCUM with in_valid=0, the block SHALL hold its state, accumulator and counter, with no timeout.
REQ-025 In HOLD, out_valid SHALL be 1, and acc_out and overflow SHALL stay stable until out_ready=1.
REQ-026 When out_valid=1 and out_ready=1 in the same cycle, the block SHALL return to IDLE on the next cycle; out_ready outside HOLD SHALL be ignored.
REQ-027 acc_out SHALL keep the last result in IDLE until the next start.

Reset
REQ-028 When rst_n=0, the block SHALL immediately, independent of clk, enter IDLE and force acc_out=0, overflow=0, counter=0, out_valid=0, in_ready=0 and busy=0.
REQ-029 A reset asserted mid-ACCUM or mid-HOLD SHALL abort the operation with no result produced; the first start after rst_n rises SHALL be honoured.

Verification
REQ-030 Scenario: reset, then start with num_terms=3 and terms {0,0x0C}, {1,0x15}, {0,0x80} -> out_valid=1 one cycle after the third term, with acc_out=0x1A1 and overflow=0.
REQ-031 Scenario: ACC_W=12, num_terms=9, every term {1,0xFF} -> acc_out=0x1F7 and overflow=1.
REQ-032 Scenario: start with num_terms=0 -> the cycle after start, out_valid=1 and acc_out=0; no term is accepted.
REQ-033 Scenario: num_terms=2 with in_valid gaps of 3 idle cycles, then out_ready held 0 for 4 cycles in HOLD -> the result is stable throughout, and IDLE is reached one cycle after out_ready=1.
REQ-034 Scenario: start pulsed during ACCUM and HOLD -> no effect on the counter or result.
REQ-035 Scenario: rst_n driven low between clock edges after 1 of 3 terms -> all outputs go to 0 immediately; a following start with num_terms=1 and term {0,0x05} gives acc_out=0x005.
